dmem_dma: RTL
=============

# dmem_dma

Word-copy DMA engine that is the initiator on the Beta data-memory port. Given source word address, destination word address and word count, it reads each word through the port and writes it back at the destination, one word every two cycles. It shares the data memory with the Beta core through an external mux. Software must keep the core off the port while `busy` is high.

## Interface
Parameters:
- `WORDS`, 1024: data-memory depth in words. Byte-address space is 4*WORDS.
- `LEN_W`, 11: width of the `len` input and the remaining-count register; maximum transfer is 2^LEN_W−1 words.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a copy; sampled only in IDLE.
- `abort`  in  1: stop an active copy.
- `srcAddr`  in  32: source byte address.
- `dstAddr`  in  32: destination byte address.
- `len`  in  LEN_W: number of words to copy.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when a request finishes, whether it succeeded or failed.
- `err`  out  1: valid only with `done`. High for misalignment, out of range, or abort.
- `wordsDone`  out  LEN_W: words written so far in the current or most recent request.
- `memAddr`  out  32: byte address to the memory.
- `memWriteData`  out  32: write data to the memory.
- `MemWrite`  out  1: write strobe. The memory commits the write at the rising edge ending the cycle.
- `MemRead`  out  1: read enable. Read data is combinational in the same cycle.
- `memReadData`  in  32: read data from the memory.

## Operation
States: IDLE, CHECK, READ, WRITE, DONE. The state enum lives in the package.

- **IDLE**
  - `start`=1: latch `srcAddr`, `dstAddr`, `len` into `srcPtr`, `dstPtr`, `remain`; clear `wordsDone`; go to CHECK.
- **CHECK** (one cycle, no memory access):
  - `err` condition: `srcPtr[1:0]`≠0, or `dstPtr[1:0]`≠0, or `srcPtr + 4*remain` > 4*WORDS, or `dstPtr + 4*remain` > 4*WORDS.
  - Compute the range sums in 33 bits so they cannot wrap.
  - `err` condition → DONE with `errReg`=1.
  - Otherwise `remain`=0 → DONE with `errReg`=0.
  - Otherwise → READ.
- **READ**
  - Drive `MemRead`=1, `memAddr`=`srcPtr`.
  - Capture `memReadData` into `dataReg` at the edge.
  - `srcPtr` += 4. Go to WRITE.
- **WRITE**
  - Drive `MemWrite`=1, `memAddr`=`dstPtr`, `memWriteData`=`dataReg`.
  - At the edge: `dstPtr` += 4, `remain` −= 1, `wordsDone` += 1.
  - `remain` was 1 → DONE; otherwise → READ.
- **DONE**
  - `done`=1; `err`=`errReg`. Next state IDLE.
- **abort**
  - Sampled in READ or WRITE: next state DONE, `errReg`=1.
  - The memory access driven in the current cycle still completes, so a WRITE-cycle abort commits that word and counts it in `wordsDone`.
  - Ignored in IDLE, CHECK and DONE.
- `start` outside IDLE is ignored and not queued.
- Overlapping regions: strictly ascending read-then-write per word. With `dst` > `src` and overlap, source data is replicated; this is defined behaviour, not an error.
- Outside READ/WRITE: `memAddr`, `memWriteData`, `MemRead`, `MemWrite` are 0.

## Timing
- Reset (async assert) values:
  - state IDLE.
  - `busy`, `done`, `err`, `MemRead`, `MemWrite` = 0.
  - `memAddr`, `memWriteData`, `wordsDone` = 0.
- Reset mid-copy:
  - Immediate return to IDLE; no further strobes, no `done` pulse.
  - Words already written stay in memory.
- `start` sampled at edge E0. Then:
  - CHECK in cycle 1.
  - For word k (k = 0..N−1): READ in cycle 2+2k, WRITE in cycle 3+2k.
  - `done` in cycle 2N+2; IDLE in cycle 2N+3.
  - Total: 2N+3 cycles from `start` to IDLE.
- Error or zero-length requests: `done` in cycle 2, IDLE in cycle 3.
- `busy` rises in cycle 1 and falls in cycle 2N+3.
- A new `start` is accepted on the edge that enters IDLE+1, i.e. the first IDLE cycle.
- All memory-port outputs are registered-state decodes: no combinational path from `start` or `abort` to the port.

## Structure
- Package `dmem_dma_pkg` holds:
  - state enum `dma_state_t`;
  - `WORD_BYTES`=4;
  - localparam for the 33-bit range-check width.
- One sub-module is natural: `dmem_dma_chk`, a combinational alignment/range checker. Inputs: two pointers and a count; output: `err`.
- The FSM, pointers and counters stay in `dmem_dma`.

## Test plan
Preload the memory with word i = 0xA000_0000 + i.

- **Basic copy:** src=0x10, dst=0x400, len=4. Expect:
  - memory words 256..259 = 0xA000_0004..0xA000_0007;
  - `done` in cycle 10, `err`=0, `wordsDone`=4.
- **Misaligned:** src=0x12, len=3. Expect `done`+`err` in cycle 2, no `MemRead`/`MemWrite` ever asserted, memory unchanged.
- **Range:** dst=0xFF8, len=3 (WORDS=1024). Expect `err`.
- **Range boundary:** dst=0xFF8, len=2. Expect success; words 1022 and 1023 written.
- **Overlap:** src=0x0, dst=0x4, len=3. Expect words 1..3 all = 0xA000_0000.
- **Abort:** abort asserted in the second WRITE cycle of a len=5 copy. Expect:
  - exactly 2 words written;
  - `wordsDone`=2;
  - `done`+`err` next cycle.
- **Reset:** `rst_n` low during a READ. Expect:
  - outputs 0 immediately;
  - no `done`;
  - `start` held high during `busy` is ignored; a subsequent `start` in IDLE copies correctly.

Source files
------------

// File: rtl/dmem_dma_pkg.sv
// dmem_dma shared types and constants.
// FSM state enum, word size and range-check width.
package dmem_dma_pkg;

  localparam int WORD_BYTES = 4;
  localparam int RANGE_W    = 33;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } dma_state_t;

endpackage

// File: rtl/dmem_dma_chk.sv
// Alignment/range checker for one copy request.
// src/dst byte pointers, cnt words in; err out.
module dmem_dma_chk
  import dmem_dma_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int LEN_W = 11
) (
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] cnt,
  output logic             err
);

  localparam logic [RANGE_W-1:0] LIMIT =
    RANGE_W'(WORDS * WORD_BYTES);

  logic [RANGE_W-1:0] span;
  logic [RANGE_W-1:0] src_end;
  logic [RANGE_W-1:0] dst_end;
  logic               mis;
  logic               oor;

  // 33-bit sums so a pointer near 4G cannot wrap past the check
  assign span    = RANGE_W'(cnt) * RANGE_W'(WORD_BYTES);
  assign src_end = {1'b0, src} + span;
  assign dst_end = {1'b0, dst} + span;

  assign mis = (|src[1:0]) | (|dst[1:0]);
  assign oor = (src_end > LIMIT) | (dst_end > LIMIT);
  assign err = mis | oor;

endmodule

// File: rtl/dmem_dma.sv
// Word-copy DMA initiator on the data-memory port.
// start/abort/src/dst/len in; busy/done/err/wordsDone and mem port out.
module dmem_dma
  import dmem_dma_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      srcAddr,
  input  logic [31:0]      dstAddr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] wordsDone,
  output logic [31:0]      memAddr,
  output logic [31:0]      memWriteData,
  output logic             MemWrite,
  output logic             MemRead,
  input  logic [31:0]      memReadData
);

  dma_state_t       state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [31:0]      data_reg;
  logic [LEN_W-1:0] remain;
  logic             err_reg;
  logic             chk_err;

  localparam logic [31:0] STEP = 32'(WORD_BYTES);

  dmem_dma_chk #(
    .WORDS (WORDS),
    .LEN_W (LEN_W)
  ) u_chk (
    .src (src_ptr),
    .dst (dst_ptr),
    .cnt (remain),
    .err (chk_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      data_reg  <= '0;
      remain    <= '0;
      err_reg   <= 1'b0;
      wordsDone <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            src_ptr   <= srcAddr;
            dst_ptr   <= dstAddr;
            remain    <= len;
            wordsDone <= '0;
            err_reg   <= 1'b0;
            state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (chk_err) begin
            err_reg <= 1'b1;
            state   <= ST_DONE;
          end else if (remain == '0) begin
            state <= ST_DONE;
          end else begin
            state <= ST_READ;
          end
        end
        ST_READ: begin
          data_reg <= memReadData;
          src_ptr  <= src_ptr + STEP;
          if (abort) begin
            err_reg <= 1'b1;
            state   <= ST_DONE;
          end else begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // the write in flight commits even on abort
          dst_ptr   <= dst_ptr + STEP;
          remain    <= remain - 1'b1;
          wordsDone <= wordsDone + 1'b1;
          if (abort) begin
            err_reg <= 1'b1;
            state   <= ST_DONE;
          end else if (remain == LEN_W'(1)) begin
            state <= ST_DONE;
          end else begin
            state <= ST_READ;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  logic rd;
  logic wr;

  assign rd       = (state == ST_READ);
  assign wr       = (state == ST_WRITE);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign err      = done & err_reg;
  assign MemRead  = rd;
  assign MemWrite = wr;

  always_comb begin
    memAddr      = '0;
    memWriteData = '0;
    unique case (1'b1)
      rd: begin
        memAddr = src_ptr;
      end
      wr: begin
        memAddr      = dst_ptr;
        memWriteData = data_reg;
      end
      default: begin
      end
    endcase
  end

endmodule
